// File: rtl/dvsd_8216m2_mul_pkg.sv
// Shared widths, product type and partial-product row helper for the 8x8 unsigned multiplier.
package dvsd_8216m2_mul_pkg;

  localparam int OPW = 8;
  localparam int PW  = 16;

  typedef logic [PW-1:0] product_t;

  // One shifted row of the AND array: operand A gated by a single B bit.
  function automatic product_t ppRow(input logic [OPW-1:0] a, input logic bBit, input int shift);
    product_t row;
    row = product_t'(a & {OPW{bBit}});
    return row << shift;
  endfunction

endpackage

// File: rtl/dvsd_8216m2_mul_ksadd.sv
// Adder cells for the multiplier: half adder, 3:2 compressor, a 16-bit row compressor
// built from them, and the 16-bit Kogge-Stone final adder.
module halfadder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;
endmodule

module compressor3to2 (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// Reduces three 16-bit rows to sum + carry rows. Columns below HA_BELOW have a
// known-zero third row, so a half adder suffices there.
module CsaRow16 #(
  parameter int unsigned HA_BELOW = 0
) (
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic [15:0] z_i,
  output logic [15:0] sum_o,
  output logic [15:0] carry_o
);
  logic [15:0] carryBits;
  logic        unusedTopCarry;

  genvar k;
  for (k = 0; k < 16; k++) begin : gCol
    if (k < HA_BELOW) begin : gHa
      logic unusedZ;
      assign unusedZ = z_i[k];
      halfadder uHa (
        .a_i    (x_i[k]),
        .b_i    (y_i[k]),
        .sum_o  (sum_o[k]),
        .carry_o(carryBits[k])
      );
    end else begin : gFa
      compressor3to2 uFa (
        .a_i    (x_i[k]),
        .b_i    (y_i[k]),
        .c_i    (z_i[k]),
        .sum_o  (sum_o[k]),
        .carry_o(carryBits[k])
      );
    end
  end

  // The rows never sum past 0xFE01, so the column-15 carry is always zero.
  assign carry_o        = {carryBits[14:0], 1'b0};
  assign unusedTopCarry = carryBits[15];
endmodule

module ksadd16b (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);
  logic [15:0] p0;
  logic [15:0] g0;
  logic [15:0] carries;
  logic        unusedTopP;

  assign p0 = a_i ^ b_i;
  assign g0 = {a_i[15:1] & b_i[15:1], (a_i[0] & b_i[0]) | (p0[0] & cin_i)};

  genvar l, k;
  for (l = 0; l <= 4; l++) begin : gLevel
    logic [15:0] g;
    logic [15:0] p;
    if (l == 0) begin : gInit
      assign g = g0;
      assign p = p0;
    end else begin : gPrefix
      for (k = 0; k < 16; k++) begin : gBit
        if (k >= (1 << (l - 1))) begin : gMerge
          assign g[k] = gLevel[l-1].g[k] | (gLevel[l-1].p[k] & gLevel[l-1].g[k-(1<<(l-1))]);
          assign p[k] = gLevel[l-1].p[k] & gLevel[l-1].p[k-(1<<(l-1))];
        end else begin : gPass
          assign g[k] = gLevel[l-1].g[k];
          assign p[k] = gLevel[l-1].p[k];
        end
      end
    end
  end

  // Carry-in is folded into bit 0's generate, so every group generate is a carry.
  assign carries    = {gLevel[4].g[14:0], cin_i};
  assign sum_o      = p0 ^ carries;
  assign cout_o     = gLevel[4].g[15];
  assign unusedTopP = ^gLevel[4].p;
endmodule

// File: rtl/dvsd_8216m2_mul.sv
// Unsigned 8x8 multiplier: AND array, four-level 3:2 reduction, Kogge-Stone final
// add and a single registered 16-bit product on scalar bit ports.
module dvsd_8216m2_mul
  import dvsd_8216m2_mul_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a0, input logic a1, input logic a2, input logic a3,
  input  logic a4, input logic a5, input logic a6, input logic a7,
  input  logic b0, input logic b1, input logic b2, input logic b3,
  input  logic b4, input logic b5, input logic b6, input logic b7,
  output logic m0,  output logic m1,  output logic m2,  output logic m3,
  output logic m4,  output logic m5,  output logic m6,  output logic m7,
  output logic m8,  output logic m9,  output logic m10, output logic m11,
  output logic m12, output logic m13, output logic m14, output logic m15
);
  logic [OPW-1:0] opA;
  logic [OPW-1:0] opB;
  product_t       pp [OPW];
  product_t       s1a, c1a, s1b, c1b;
  product_t       s2a, c2a, s2b, c2b;
  product_t       s3, c3, s4, c4;
  product_t       productD;
  product_t       productQ;
  logic           unusedFinalCarry;

  assign opA = {a7, a6, a5, a4, a3, a2, a1, a0};
  assign opB = {b7, b6, b5, b4, b3, b2, b1, b0};

  genvar j;
  for (j = 0; j < OPW; j++) begin : gPp
    assign pp[j] = ppRow(opA, opB[j], j);
  end

  // Wallace schedule 8 -> 6 -> 4 -> 3 -> 2 rows; HA_BELOW marks where the third row is still zero.
  CsaRow16 #(.HA_BELOW(2)) uL1a (.x_i(pp[0]), .y_i(pp[1]), .z_i(pp[2]), .sum_o(s1a), .carry_o(c1a));
  CsaRow16 #(.HA_BELOW(5)) uL1b (.x_i(pp[3]), .y_i(pp[4]), .z_i(pp[5]), .sum_o(s1b), .carry_o(c1b));

  CsaRow16 #(.HA_BELOW(3)) uL2a (.x_i(s1a), .y_i(c1a),   .z_i(s1b),   .sum_o(s2a), .carry_o(c2a));
  CsaRow16 #(.HA_BELOW(7)) uL2b (.x_i(c1b), .y_i(pp[6]), .z_i(pp[7]), .sum_o(s2b), .carry_o(c2b));

  CsaRow16 #(.HA_BELOW(5)) uL3  (.x_i(s2a), .y_i(c2a), .z_i(s2b), .sum_o(s3), .carry_o(c3));

  CsaRow16 #(.HA_BELOW(7)) uL4  (.x_i(s3),  .y_i(c3),  .z_i(c2b), .sum_o(s4), .carry_o(c4));

  ksadd16b uFinal (
    .a_i   (s4),
    .b_i   (c4),
    .cin_i (1'b0),
    .sum_o (productD),
    .cout_o(unusedFinalCarry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      productQ <= '0;
    end else begin
      productQ <= productD;
    end
  end

  assign {m15, m14, m13, m12, m11, m10, m9, m8} = productQ[15:8];
  assign {m7,  m6,  m5,  m4,  m3,  m2,  m1, m0} = productQ[7:0];

endmodule

// File: tb/tb_dvsd_8216m2_mul.sv
// Self-checking bench for dvsd_8216m2_mul: vector table, hand-written reset sequences,
// random pairs and an exhaustive sweep, all scored through an expected-product queue.
module tb_dvsd_8216m2_mul;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        rst;
    logic [15:0] expM;
    string       name;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [7:0]  aVec;
  logic [7:0]  bVec;
  logic [15:0] mBits;
  logic [15:0] expQ [$];
  vec_t        vecs [14];
  int          checks;
  int          failures;

  dvsd_8216m2_mul dut (
    .clk(clk), .rst(rst),
    .a0(aVec[0]), .a1(aVec[1]), .a2(aVec[2]), .a3(aVec[3]),
    .a4(aVec[4]), .a5(aVec[5]), .a6(aVec[6]), .a7(aVec[7]),
    .b0(bVec[0]), .b1(bVec[1]), .b2(bVec[2]), .b3(bVec[3]),
    .b4(bVec[4]), .b5(bVec[5]), .b6(bVec[6]), .b7(bVec[7]),
    .m0(mBits[0]),   .m1(mBits[1]),   .m2(mBits[2]),   .m3(mBits[3]),
    .m4(mBits[4]),   .m5(mBits[5]),   .m6(mBits[6]),   .m7(mBits[7]),
    .m8(mBits[8]),   .m9(mBits[9]),   .m10(mBits[10]), .m11(mBits[11]),
    .m12(mBits[12]), .m13(mBits[13]), .m14(mBits[14]), .m15(mBits[15])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand pair, queue its expected product, and move 1 unit past the edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic r,
                               input logic [15:0] expM);
    aVec = a;
    bVec = b;
    rst  = r;
    expQ.push_back(expM);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name);
    logic [15:0] expM;
    checks++;
    if (expQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s: scoreboard empty, actual=0x%04h", name, mBits);
    end else begin
      expM = expQ.pop_front();
      if (mBits !== expM) begin
        failures++;
        $display("[TB] FAIL %s: actual m15..m0=0x%04h required=0x%04h", name, mBits, expM);
      end
    end
  endtask

  task automatic applyAndCheck(input logic [7:0] a, input logic [7:0] b, input logic r,
                               input logic [15:0] expM, input string name);
    applyStimulus(a, b, r, expM);
    checkOutput(name);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    aVec     = 8'h00;
    bVec     = 8'h00;

    vecs[0]  = '{8'hFF, 8'hFF, 1'b1, 16'h0000, "resetHold0"};
    vecs[1]  = '{8'hFF, 8'hFF, 1'b1, 16'h0000, "resetHold1"};
    vecs[2]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, "resetRelease"};
    vecs[3]  = '{8'h00, 8'hA5, 1'b0, 16'h0000, "zeroA"};
    vecs[4]  = '{8'h01, 8'hA5, 1'b0, 16'h00A5, "identA"};
    vecs[5]  = '{8'hA5, 8'h01, 1'b0, 16'h00A5, "identB"};
    vecs[6]  = '{8'h80, 8'h02, 1'b0, 16'h0100, "msbShift"};
    vecs[7]  = '{8'hFF, 8'h01, 1'b0, 16'h00FF, "ffTimes1"};
    vecs[8]  = '{8'hFF, 8'h02, 1'b0, 16'h01FE, "ffTimes2"};
    vecs[9]  = '{8'h10, 8'h10, 1'b0, 16'h0100, "nibbleSq"};
    vecs[10] = '{8'd3,   8'd5,   1'b0, 16'd15,    "b2b0"};
    vecs[11] = '{8'd12,  8'd12,  1'b0, 16'd144,   "b2b1"};
    vecs[12] = '{8'd200, 8'd100, 1'b0, 16'd20000, "b2b2"};
    vecs[13] = '{8'd255, 8'd255, 1'b0, 16'd65025, "b2b3"};

    for (int i = 0; i < 14; i++) begin
      applyAndCheck(vecs[i].a, vecs[i].b, vecs[i].rst, vecs[i].expM, vecs[i].name);
    end

    // Reset lands on the edge that would have loaded 200*100.
    applyAndCheck(8'd3,   8'd5,   1'b0, 16'd15,  "midPre0");
    applyAndCheck(8'd12,  8'd12,  1'b0, 16'd144, "midPre1");
    applyAndCheck(8'd200, 8'd100, 1'b1, 16'd0,   "midReset");
    applyAndCheck(8'd7,   8'd9,   1'b0, 16'd63,  "midRelease");

    // Reset held while operands keep changing must keep the product at zero.
    applyAndCheck(8'h5A, 8'hC3, 1'b1, 16'h0000, "holdVary0");
    applyAndCheck(8'h81, 8'h7E, 1'b1, 16'h0000, "holdVary1");
    applyAndCheck(8'h81, 8'h7E, 1'b0, 16'h3F7E, "holdVaryRelease");

    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      applyAndCheck(ra, rb, 1'b0, 16'(ra) * 16'(rb), "random");
    end

    for (int i = 0; i < 65536; i++) begin
      ra = 8'(i >> 8);
      rb = 8'(i);
      applyAndCheck(ra, rb, 1'b0, 16'(ra) * 16'(rb), "sweep");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
